// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage.
// XLEN here sets the datapath width of the whole stage (32 or 64).
package imm_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } imm_src_e;

    typedef struct packed {
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] target_addr;
        logic            imm_illegal;
    } imm_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction, sign extension and PC-relative target.
// IMMGEN_ZICSR_EN enables the CSR zimm (Z) format; otherwise it decodes as reserved.
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:7]     instr_i,
    input  logic [2:0]      imm_src_i,
    input  logic [XLEN-1:0] pc_i,
    output imm_payload_t    payload_o_c
);

    logic [XLEN-1:0] imm;
    logic            illegal;

    // Size casts of signed operands sign-extend from the format's top bit.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src_i)
            IMM_I: imm = XLEN'($signed(instr_i[31:20]));
            IMM_S: imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            IMM_B: imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
            IMM_J: imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
            IMM_U: imm = XLEN'($signed({instr_i[31:12], 12'b0}));
`ifdef IMMGEN_ZICSR_EN
            IMM_Z: imm = XLEN'(instr_i[19:15]);
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Illegal formats leave imm at zero, so the target collapses to PC.
    assign payload_o_c = '{imm_ext:     imm,
                           target_addr: pc_i + imm,
                           imm_illegal: illegal};

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate/target stage: decode feeding a two-entry skid pipeline register.
// Build with IMMGEN_ZICSR_EN to accept the Z (CSR zimm) format.
module imm_gen_stage
    import imm_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instr,
    input  logic [2:0]      ImmSrc,
    input  logic [XLEN-1:0] PC,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic [XLEN-1:0] TargetAddr,
    output logic            ImmIllegal
);

    imm_payload_t dec_c;
    imm_payload_t or_q, or_d;
    imm_payload_t sk_q, sk_d;
    state_e       state_q, state_d;
    logic         out_valid_q, out_valid_d;
    logic         accept, pop;
    logic         unused_opcode;

    imm_decode u_decode (
        .instr_i     (Instr[31:7]),
        .imm_src_i   (ImmSrc),
        .pc_i        (PC),
        .payload_o_c (dec_c)
    );

    // The opcode field carries no immediate bits.
    assign unused_opcode = ^Instr[6:0];

    assign in_ready = (state_q != TWO) && !reset;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    // Next-state and storage updates; flush discards everything held.
    always_comb begin
        state_d     = state_q;
        or_d        = or_q;
        sk_d        = sk_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        or_d        = dec_c;
                        state_d     = ONE;
                        out_valid_d = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        sk_d    = dec_c;
                        state_d = TWO;
                    end else if (accept && pop) begin
                        or_d = dec_c;
                    end else if (pop) begin
                        state_d     = EMPTY;
                        out_valid_d = 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        or_d    = sk_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            or_q        <= '0;
            sk_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            or_q        <= or_d;
            sk_q        <= sk_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ImmExt     = or_q.imm_ext;
    assign TargetAddr = or_q.target_addr;
    assign ImmIllegal = or_q.imm_illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: directed vectors plus randomized traffic
// against an arithmetic reference model of the immediate formats and a 2-deep queue.
module tb_imm_gen_stage;

    localparam int unsigned XL = imm_pkg::XLEN;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   Instr;
    logic [2:0]    ImmSrc;
    logic [XL-1:0] PC, ImmExt, TargetAddr;
    logic          ImmIllegal;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    imm_gen_stage dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Instr      (Instr),
        .ImmSrc     (ImmSrc),
        .PC         (PC),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ImmExt     (ImmExt),
        .TargetAddr (TargetAddr),
        .ImmIllegal (ImmIllegal)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xmask();
        return (XL == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << XL) - 64'd1);
    endfunction

    // Reference: immediate value as a signed integer built from weighted fields.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [2:0] src,
                                       input logic [63:0] p);
        exp_t   e;
        longint s;
        longint v;
        s     = ins[31] ? -64'sd1 : 64'sd0;
        v     = 0;
        e.ill = 1'b0;
        case (src)
            3'd0: v = s * 2048 + longint'(ins[30:20]);
            3'd1: v = s * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            3'd2: v = s * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2;
            3'd3: v = s * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2;
            3'd4: v = s * 64'sh8000_0000 + longint'(ins[30:12]) * 4096;
`ifdef IMMGEN_ZICSR_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v) & xmask();
        e.tgt = (p + e.imm) & xmask();
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; the model queue is updated at the clock edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] p, input logic ordy, input logic fl,
                        input logic rst);
        logic acc;
        in_valid  = v;
        Instr     = ins;
        ImmSrc    = src;
        PC        = XL'(p);
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (rst || fl) q.delete();
        else if (acc) q.push_back(ref_model(ins, src, 64'(PC)));
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 3'd0, 64'h0, ordy, 1'b0, 1'b0);
    endtask

    // Monitor: occupancy/handshake checks and in-order payload comparison on each pop.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("in_ready", 64'(in_ready), 64'(!reset && (q.size() < 2)));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && out_ready && !flush && !reset) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_empty: output popped with nothing expected at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("ImmExt", 64'(ImmExt), e.imm);
                    chk("TargetAddr", 64'(TargetAddr), e.tgt);
                    chk("ImmIllegal", 64'(ImmIllegal), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        logic [63:0] ones;
        logic [31:0] zinst;
        ones      = 64'hFFFF_FFFF_FFFF_FFFF & xmask();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Instr     = '0;
        ImmSrc    = '0;
        PC        = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_ImmExt", 64'(ImmExt), 64'd0);
        chk("rst_TargetAddr", 64'(TargetAddr), 64'd0);
        chk("rst_ImmIllegal", 64'(ImmIllegal), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // B-type backward branch, then back-to-back I, J, U.
        step(1'b1, 32'hFE00_0EE3, 3'd2, 64'h100, 1'b1, 1'b0, 1'b0);
        chk("b_imm", 64'(ImmExt), 64'hFFFF_FFFF_FFFF_FFFC & xmask());
        chk("b_tgt", 64'(TargetAddr), 64'hFC);
        chk("b_ill", 64'(ImmIllegal), 64'd0);
        step(1'b1, 32'hFFF0_0093, 3'd0, 64'h200, 1'b1, 1'b0, 1'b0);
        chk("i_imm", 64'(ImmExt), ones);
        step(1'b1, 32'h0080_006F, 3'd3, 64'h300, 1'b1, 1'b0, 1'b0);
        chk("j_imm", 64'(ImmExt), 64'h8);
        chk("j_tgt", 64'(TargetAddr), 64'h308);
        step(1'b1, 32'h1234_50B7, 3'd4, 64'h400, 1'b1, 1'b0, 1'b0);
        chk("u_imm", 64'(ImmExt), 64'h1234_5000);
        chk("u_valid", 64'(out_valid), 64'd1);
        idle(1'b1);

        // Backpressure: two accepted, third held off, then drained in order.
        step(1'b1, 32'h0010_0093, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0093, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("two_in_ready", 64'(in_ready), 64'd0);
        chk("two_hold_a", 64'(ImmExt), 64'd1);
        step(1'b1, 32'h0030_0093, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("two_hold_b", 64'(ImmExt), 64'd1);
        step(1'b1, 32'h0030_0093, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_b", 64'(ImmExt), 64'd2);
        step(1'b1, 32'h0030_0093, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_c", 64'(ImmExt), 64'd3);
        idle(1'b1);

        // Flush while full with a concurrent offer.
        step(1'b1, 32'h0040_0093, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0050_0093, 3'd0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0060_0093, 3'd0, 64'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        idle(1'b1);

        // CSR zimm and reserved formats.
        zinst = 32'h000F_8073;
        step(1'b1, zinst, 3'd5, 64'h40, 1'b1, 1'b0, 1'b0);
`ifdef IMMGEN_ZICSR_EN
        chk("z_imm", 64'(ImmExt), 64'h1F);
        chk("z_ill", 64'(ImmIllegal), 64'd0);
`else
        chk("z_imm", 64'(ImmExt), 64'h0);
        chk("z_ill", 64'(ImmIllegal), 64'd1);
`endif
        step(1'b1, 32'hFFFF_FFFF, 3'd7, 64'h80, 1'b1, 1'b0, 1'b0);
        chk("rsv_ill", 64'(ImmIllegal), 64'd1);
        chk("rsv_imm", 64'(ImmExt), 64'd0);
        chk("rsv_tgt", 64'(TargetAddr), 64'h80);
        idle(1'b1);

        // Reset while full.
        step(1'b1, 32'h0070_0093, 3'd0, 64'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0080_0093, 3'd0, 64'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0090_0093, 3'd0, 64'h10, 1'b0, 1'b0, 1'b1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_imm", 64'(ImmExt), 64'd0);
        chk("midrst_tgt", 64'(TargetAddr), 64'd0);
        chk("midrst_ill", 64'(ImmIllegal), 64'd0);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered immediate-generation and target-address stage for the RV32/RV64 core. It decodes every base-ISA immediate format (I, S, B, U, J) from a 32-bit instruction and sign-extends it to XLEN. It also computes PC + ImmExt. Results are delivered through a valid/ready pipeline register with a one-entry skid buffer. It sits between fetch/decode and execute, and replaces the purely combinational extender on the pipelined datapath.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries; has priority over accept
- in_valid  in  1  upstream offers Instr/ImmSrc/PC
- in_ready  out  1  stage can accept this cycle
- Instr  in  32  instruction word
- ImmSrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110/111 reserved
- PC  in  XLEN  address of Instr
- out_valid  out  1  ImmExt/TargetAddr/ImmIllegal are valid
- out_ready  in  1  downstream consumes when high with out_valid
- ImmExt  out  XLEN  extended immediate
- TargetAddr  out  XLEN  PC + ImmExt, modulo 2^XLEN
- ImmIllegal  out  1  ImmSrc was reserved or disabled

## Operation
- Immediate formats. All are sign-extended from Instr[31] to XLEN unless noted.
  - I: Instr[31:20].
  - S: {Instr[31:25], Instr[11:7]}.
  - B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - U: {Instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - Z: zero-extended Instr[19:15]; only when enabled (see Configuration).
- Reserved or disabled ImmSrc: ImmExt = 0, TargetAddr = PC, ImmIllegal = 1. ImmIllegal is 0 for every legal format.
- Storage: an output register (OR) and a skid register (SK), each holding {ImmExt, TargetAddr, ImmIllegal}.
- States:
  - EMPTY: nothing held.
  - ONE: OR valid.
  - TWO: OR and SK valid.
- Handshake signals:
  - in_ready = (state != TWO) && !reset.
  - out_valid = (state != EMPTY).
  - accept = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Transitions, when flush=0:
  - EMPTY: accept loads OR, go to ONE.
  - ONE, accept && !pop: load SK, go to TWO.
  - ONE, accept && pop: reload OR, stay in ONE.
  - ONE, !accept && pop: go to EMPTY.
  - TWO, pop: SK moves to OR, go to ONE. No accept is possible in TWO.
- flush=1: next state is EMPTY. Concurrent accept and pop are ignored; upstream sees in_ready but the data is dropped.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush or reset.
- Output payload stays stable while out_valid && !out_ready.

## Timing
- Latency: accept in cycle N gives out_valid in cycle N+1 (from EMPTY).
- Throughput: 1 per cycle with out_ready held high.
- Reset, applied at a clock edge:
  - state = EMPTY; OR and SK payloads = 0.
  - out_valid = 0, ImmExt = 0, TargetAddr = 0, ImmIllegal = 0.
  - in_ready = 0 while reset is high, and 1 in the first cycle after reset.
- Reset mid-transfer: all held entries are lost, with no partial update.
- Simultaneous flush and reset: same result as reset.
- All outputs except in_ready come directly from registers. in_ready depends only on state and reset, never combinationally on in_valid or out_ready.

## Configuration
- IMMGEN_ZICSR_EN:
  - Defined: ImmSrc 101 selects Z format, ImmIllegal = 0.
  - Undefined: 101 behaves as reserved (ImmExt 0, ImmIllegal 1).
- No other behaviour changes.

## Structure
- Shared package imm_pkg holds:
  - imm_src_e enum (IMM_I … IMM_Z, with 3-bit encodings as above).
  - imm_payload_t struct {ImmExt, TargetAddr, ImmIllegal}, parametrised via XLEN localparam.
  - State enum {EMPTY, ONE, TWO}.
- Sub-module imm_decode: purely combinational Instr/ImmSrc/PC → imm_payload_t. The top instance contains only the skid/handshake logic.

## Test plan
- XLEN=32, PC=0x100, Instr=0xFE000EE3, ImmSrc=010, out_ready=1 → next cycle ImmExt=0xFFFFFFFC, TargetAddr=0x000000FC, ImmIllegal=0.
- Back-to-back I (0xFFF00093 → 0xFFFFFFFF), J (0x0080006F → 0x00000008), U (0x123450B7 → 0x12345000) at 1/cycle → three outputs in order, with no bubbles.
- out_ready=0 while offering 3 items → two accepted, in_ready=0 in TWO, output held stable. Raising out_ready drains them in order, then accepts the third.
- flush asserted in TWO together with in_valid → out_valid=0 next cycle, nothing delivered.
- ImmSrc=101, Instr[19:15]=11111 → ImmExt=0x1F, ImmIllegal=0 with IMMGEN_ZICSR_EN; ImmExt=0, ImmIllegal=1 without. ImmSrc=111 → ImmIllegal=1 in both builds.
- XLEN=64, U-type 0x800000B7 → ImmExt=0xFFFFFFFF80000000. Reset asserted in TWO → all outputs 0 and in_ready=1 one cycle after deassertion.
